// File: rtl/mips_lsu_pkg.sv
// Shared types and small decode helpers for the MIPS load/store unit.
package mips_lsu_pkg;

  // Memory operation requested by the core; encoding matches the decoder.
  typedef enum logic [2:0] {
    LB  = 3'd0,
    LBU = 3'd1,
    LH  = 3'd2,
    LHU = 3'd3,
    LW  = 3'd4,
    SB  = 3'd5,
    SH  = 3'd6,
    SW  = 3'd7
  } lsu_op_t;

  // Sequencer states of the unit.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } lsu_state_t;

  // Any of the five load flavours.
  function automatic logic is_load(input lsu_op_t op);
    return (op == LB) || (op == LBU) || (op == LH) || (op == LHU) || (op == LW);
  endfunction

  // Stores narrower than a memory word need a read-modify-write.
  function automatic logic is_sub_store(input lsu_op_t op);
    return (op == SB) || (op == SH);
  endfunction

  // Halfword accesses must sit on an even byte offset.
  function automatic logic is_half(input lsu_op_t op);
    return (op == LH) || (op == LHU) || (op == SH);
  endfunction

  // Word accesses cover every lane and must be lane-0 aligned.
  function automatic logic is_word(input lsu_op_t op);
    return (op == LW) || (op == SW);
  endfunction

endpackage

// File: rtl/mips_lsu_lane_align.sv
// Big-endian lane steering: load extraction with sign/zero extension and
// merging of store data into a previously read memory word.
module mips_lsu_lane_align
  import mips_lsu_pkg::*;
#(
  parameter int LANES = 4,
  localparam int W     = 8 * LANES,
  localparam int OFF_W = $clog2(LANES)
) (
  input  lsu_op_t                  op,
  input  logic [OFF_W-1:0]         off,
  input  logic [0:LANES-1][7:0]    rd_lanes,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             load_data,
  output logic [0:LANES-1][7:0]    wr_lanes
);

  // An aligned halfword always starts on an even lane, so its second lane
  // is simply off with bit 0 set; this never wraps past the last lane.
  logic [OFF_W-1:0] off_pair;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;

  assign off_pair = off | OFF_W'(1);
  assign byte_sel = rd_lanes[off];
  assign half_sel = {rd_lanes[off], rd_lanes[off_pair]};

  // Pick the addressed bytes out of the read word and extend them to W.
  always_comb begin
    load_data = rd_lanes;
    case (op)
      LB:      load_data = {{(W-8){byte_sel[7]}}, byte_sel};
      LBU:     load_data = {{(W-8){1'b0}}, byte_sel};
      LH:      load_data = {{(W-16){half_sel[15]}}, half_sel};
      LHU:     load_data = {{(W-16){1'b0}}, half_sel};
      default: load_data = rd_lanes;
    endcase
  end

  // Overlay store bytes on the read word; SW replaces every lane outright.
  always_comb begin
    wr_lanes = rd_lanes;
    case (op)
      SB: wr_lanes[off] = wdata[7:0];
      SH: begin
        wr_lanes[off]      = wdata[15:8];
        wr_lanes[off_pair] = wdata[7:0];
      end
      SW:      wr_lanes = wdata;
      default: wr_lanes = rd_lanes;
    endcase
  end

endmodule

// File: rtl/mips_lsu.sv
// Load/store unit between the core datapath and a big-endian byte-lane
// memory with a single write enable and a fixed read latency.
module mips_lsu
  import mips_lsu_pkg::*;
#(
  parameter int LANES       = 4,
  parameter int ADDR_W      = 32,
  parameter int MEM_LATENCY = 1,
  localparam int W = 8 * LANES
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  lsu_op_t                  req_op,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [W-1:0]             req_wdata,
  input  logic [4:0]               req_rd,
  input  logic                     halted,
  output logic                     resp_valid,
  output logic [W-1:0]             resp_rdata,
  output logic [4:0]               resp_rd,
  output logic                     resp_err,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [0:LANES-1][7:0]    mem_data_in,
  input  logic [0:LANES-1][7:0]    mem_data_out,
  output logic                     mem_write_en
);

  localparam int OFF_W = $clog2(LANES);
  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);

  if (!(LANES == 4 || LANES == 8)) begin : g_bad_lanes
    $error("mips_lsu: LANES must be 4 or 8");
  end
  if (MEM_LATENCY < 1) begin : g_bad_latency
    $error("mips_lsu: MEM_LATENCY must be at least 1");
  end

  // Request and sequencing state captured at accept.
  lsu_state_t              state;
  logic [CNT_W-1:0]        cnt;
  lsu_op_t                 op_q;
  logic [OFF_W-1:0]        off_q;
  logic [W-1:0]            wdata_q;
  logic [4:0]              rd_q;
  logic                    err_q;
  logic [0:LANES-1][7:0]   rword_q;

  logic                    accept;
  logic [OFF_W-1:0]        req_off;
  logic                    req_mis;
  logic [W-1:0]            load_data;
  logic [0:LANES-1][7:0]   wr_lanes;

  // Byte accesses are always aligned; halves need an even offset and words
  // need offset zero.
  function automatic logic misaligned(input lsu_op_t op, input logic [OFF_W-1:0] off);
    if (is_half(op)) return off[0];
    if (is_word(op)) return off != '0;
    return 1'b0;
  endfunction

  assign req_ready = (state == IDLE) && !halted;
  assign accept    = req_valid && req_ready;
  assign req_off   = req_addr[OFF_W-1:0];
  assign req_mis   = misaligned(req_op, req_off);

  mips_lsu_lane_align #(
    .LANES(LANES)
  ) u_align (
    .op        (op_q),
    .off       (off_q),
    .rd_lanes  (rword_q),
    .wdata     (wdata_q),
    .load_data (load_data),
    .wr_lanes  (wr_lanes)
  );

  // Sequencer: accept, wait out the memory latency, optionally write, respond.
  // mem_addr is only loaded for aligned requests, so a rejected access never
  // moves the memory port.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state    <= IDLE;
      cnt      <= '0;
      op_q     <= LB;
      off_q    <= '0;
      wdata_q  <= '0;
      rd_q     <= '0;
      err_q    <= 1'b0;
      rword_q  <= '0;
      mem_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q    <= req_op;
            off_q   <= req_off;
            wdata_q <= req_wdata;
            rd_q    <= req_rd;
            err_q   <= req_mis;
            cnt     <= CNT_INIT;
            if (req_mis) begin
              state <= RESP;
            end else begin
              mem_addr <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
              state    <= (req_op == SW) ? WRITE : READ;
            end
          end
        end
        READ: begin
          if (cnt == '0) begin
            rword_q <= mem_data_out;
            state   <= is_load(op_q) ? RESP : WRITE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        WRITE:   state <= RESP;
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Response and write-port fields are gated by state so they read as zero
  // outside their own cycle, including straight after an asynchronous reset.
  assign resp_valid   = (state == RESP);
  assign resp_err     = (state == RESP) && err_q;
  assign resp_rdata   = ((state == RESP) && is_load(op_q) && !err_q) ? load_data : '0;
  assign resp_rd      = ((state == RESP) && is_load(op_q)) ? rd_q : '0;
  assign mem_write_en = (state == WRITE);
  assign mem_data_in  = (state == WRITE) ? wr_lanes : '0;

endmodule

// File: tb/tb_mips_lsu.sv
// Bench for mips_lsu: a 4-lane/latency-2 instance and an 8-lane/latency-3
// instance share one stimulus path; each has its own byte-array memory.
module tb_mips_lsu;

  localparam int LAT_A = 2;
  localparam int LAT_B = 3;

  localparam logic [2:0] OP_LB = 3'd0, OP_LBU = 3'd1, OP_LH = 3'd2, OP_LHU = 3'd3,
                         OP_LW = 3'd4, OP_SB = 3'd5, OP_SH = 3'd6, OP_SW = 3'd7;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus
  bit                     sel = 1'b0;
  logic                   req_valid = 1'b0;
  mips_lsu_pkg::lsu_op_t  req_op = mips_lsu_pkg::LB;
  logic [31:0]            req_addr = '0;
  logic [63:0]            req_wdata = '0;
  logic [4:0]             req_rd = '0;
  logic                   halted = 1'b0;

  // Instance A (4 lanes)
  logic a_req_valid, a_req_ready, a_resp_valid, a_resp_err, a_we;
  logic [31:0] a_resp_rdata, a_maddr;
  logic [4:0]  a_resp_rd;
  logic [0:3][7:0] a_mdi, a_mdo;
  // Instance B (8 lanes)
  logic b_req_valid, b_req_ready, b_resp_valid, b_resp_err, b_we;
  logic [63:0] b_resp_rdata;
  logic [31:0] b_maddr;
  logic [4:0]  b_resp_rd;
  logic [0:7][7:0] b_mdi, b_mdo;

  assign a_req_valid = req_valid & ~sel;
  assign b_req_valid = req_valid & sel;

  mips_lsu #(.LANES(4), .ADDR_W(32), .MEM_LATENCY(LAT_A)) dut_a (
    .clk(clk), .rst_b(rst_b), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata[31:0]), .req_rd(req_rd),
    .halted(halted), .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata),
    .resp_rd(a_resp_rd), .resp_err(a_resp_err), .mem_addr(a_maddr),
    .mem_data_in(a_mdi), .mem_data_out(a_mdo), .mem_write_en(a_we));

  mips_lsu #(.LANES(8), .ADDR_W(32), .MEM_LATENCY(LAT_B)) dut_b (
    .clk(clk), .rst_b(rst_b), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .halted(halted), .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata),
    .resp_rd(b_resp_rd), .resp_err(b_resp_err), .mem_addr(b_maddr),
    .mem_data_in(b_mdi), .mem_data_out(b_mdo), .mem_write_en(b_we));

  // Muxed view of the selected instance
  logic        req_ready, resp_valid, resp_err, mem_write_en;
  logic [63:0] resp_rdata, mem_data_in;
  logic [4:0]  resp_rd;
  logic [31:0] mem_addr;
  assign req_ready    = sel ? b_req_ready  : a_req_ready;
  assign resp_valid   = sel ? b_resp_valid : a_resp_valid;
  assign resp_err     = sel ? b_resp_err   : a_resp_err;
  assign mem_write_en = sel ? b_we         : a_we;
  assign resp_rdata   = sel ? b_resp_rdata : {32'h0, a_resp_rdata};
  assign mem_data_in  = sel ? b_mdi        : {32'h0, a_mdi};
  assign resp_rd      = sel ? b_resp_rd    : a_resp_rd;
  assign mem_addr     = sel ? b_maddr      : a_maddr;

  // Initial memory image: a scrambled pattern plus the directed words.
  logic [7:0] seed;
  function automatic logic [7:0] init_byte(input bit s, input logic [8:0] p);
    if (!s && p == 9'h100) return 8'h12;
    if (!s && p == 9'h101) return 8'h34;
    if (!s && p == 9'h102) return 8'h56;
    if (!s && p == 9'h103) return 8'h80;
    if (s && p >= 9'h008 && p <= 9'h00F) return 8'(p - 9'h007);
    return 8'(p[7:0] * 8'd37) ^ seed ^ (s ? 8'h5A : 8'hC3);
  endfunction

  // Bus-side memories: written only by the DUT write strobe
  logic [7:0] bm_a [0:511];
  logic [7:0] bm_b [0:511];
  bit         wr_a_flag [0:511];
  bit         wr_b_flag [0:511];
  logic [8:0] a_base, b_base;
  assign a_base = {a_maddr[8:2], 2'b00};
  assign b_base = {b_maddr[8:3], 3'b000};

  function automatic logic [7:0] bus_a(input logic [8:0] p);
    return wr_a_flag[p] ? bm_a[p] : init_byte(1'b0, p);
  endfunction
  function automatic logic [7:0] bus_b(input logic [8:0] p);
    return wr_b_flag[p] ? bm_b[p] : init_byte(1'b1, p);
  endfunction

  // Read data only becomes valid once mem_addr has been held long enough.
  logic [31:0] a_last = '1, b_last = '1;
  int a_held = 0, b_held = 0;
  logic a_ok, b_ok;
  always @(posedge clk) begin
    a_held <= (a_maddr == a_last) ? a_held + 1 : 1;
    b_held <= (b_maddr == b_last) ? b_held + 1 : 1;
    a_last <= a_maddr;
    b_last <= b_maddr;
  end
  assign a_ok = (a_maddr == a_last) ? (a_held + 1 >= LAT_A) : (LAT_A == 1);
  assign b_ok = (b_maddr == b_last) ? (b_held + 1 >= LAT_B) : (LAT_B == 1);

  always_comb begin
    for (int k = 0; k < 4; k++) a_mdo[k] = a_ok ? bus_a(a_base + 9'(k)) : 8'hEE;
    for (int k = 0; k < 8; k++) b_mdo[k] = b_ok ? bus_b(b_base + 9'(k)) : 8'hEE;
  end

  int wr_a_cnt = 0;
  always @(posedge clk) begin
    if (a_we) begin
      wr_a_cnt <= wr_a_cnt + 1;
      for (int k = 0; k < 4; k++) begin
        bm_a[a_base + 9'(k)]      <= a_mdi[k];
        wr_a_flag[a_base + 9'(k)] <= 1'b1;
      end
    end
    if (b_we) begin
      for (int k = 0; k < 8; k++) begin
        bm_b[b_base + 9'(k)]      <= b_mdi[k];
        wr_b_flag[b_base + 9'(k)] <= 1'b1;
      end
    end
  end

  // Reference byte memories for the model
  logic [7:0] ref_a [0:511];
  logic [7:0] ref_b [0:511];
  function automatic logic [7:0] rget(input bit s, input logic [8:0] p);
    return s ? ref_b[p] : ref_a[p];
  endfunction
  task automatic rset(input bit s, input logic [8:0] p, input logic [7:0] v);
    if (s) ref_b[p] = v; else ref_a[p] = v;
  endtask

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Observations from the latest transaction
  int          obs_lat, obs_wcnt;
  logic [63:0] obs_rdata, obs_wdat;
  logic [31:0] obs_waddr;
  logic [4:0]  obs_rd;
  logic        obs_err;

  // One request end-to-end, compared against the byte-level model.
  task automatic run_op(input bit s, input logic [2:0] opc, input logic [8:0] addr,
                        input logic [63:0] wd, input logic [4:0] rd, input bit halt_mid);
    int n, lanes, lat, size, exp_lat, exp_w;
    bit mis, isld, got, busy;
    logic [63:0] v, exp_rdata, exp_wdat;
    logic [8:0] base;
    lanes = s ? 8 : 4;
    lat   = s ? LAT_B : LAT_A;
    size  = (opc == OP_LB || opc == OP_LBU || opc == OP_SB) ? 1 :
            (opc == OP_LH || opc == OP_LHU || opc == OP_SH) ? 2 : lanes;
    mis   = (int'(addr) % size) != 0;
    isld  = (opc <= OP_LW);
    base  = 9'((int'(addr) / lanes) * lanes);
    exp_lat = mis ? 1 : isld ? lat + 1 : (opc == OP_SW) ? 2 : lat + 2;
    exp_rdata = '0;
    if (isld && !mis) begin
      v = '0;
      for (int i = 0; i < size; i++) v = (v << 8) | 64'(rget(s, addr + 9'(i)));
      if ((opc == OP_LB || opc == OP_LH) && v[size*8-1]) v = v | (~64'h0 << (size*8));
      if (!s) v = v & 64'hFFFF_FFFF;
      exp_rdata = v;
    end
    exp_w = (!isld && !mis) ? 1 : 0;
    exp_wdat = '0;
    if (exp_w == 1) begin
      for (int i = 0; i < size; i++) rset(s, addr + 9'(i), wd[8*(size-1-i) +: 8]);
      for (int i = 0; i < lanes; i++) exp_wdat = (exp_wdat << 8) | 64'(rget(s, base + 9'(i)));
    end

    sel = s;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    check_val("ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_op    = mips_lsu_pkg::lsu_op_t'(opc);
    req_addr  = 32'(addr);
    req_wdata = wd;
    req_rd    = rd;
    @(posedge clk);
    #1 req_valid = 1'b0;

    n = 0; got = 0; busy = 0; obs_wcnt = 0; obs_wdat = '0; obs_waddr = '0;
    while (!got && n < 30) begin
      @(negedge clk);
      n++;
      if (halt_mid && n == 1) halted = 1'b1;
      if (req_ready) busy = 1;
      if (mem_write_en) begin obs_wcnt++; obs_wdat = mem_data_in; obs_waddr = mem_addr; end
      if (resp_valid) begin
        got = 1; obs_lat = n; obs_rdata = resp_rdata; obs_rd = resp_rd; obs_err = resp_err;
      end
    end
    if (!got) begin
      check_val("resp_timeout", 0, 1);
    end else begin
      check_val("latency", 64'(obs_lat), 64'(exp_lat));
      check_val("resp_err", obs_err, mis);
      check_val("resp_rdata", obs_rdata, exp_rdata);
      check_val("resp_rd", obs_rd, isld ? rd : 5'd0);
      check_val("ready_busy", busy, 0);
    end
    check_val("write_count", 64'(obs_wcnt), 64'(exp_w));
    if (exp_w == 1 && obs_wcnt > 0) begin
      check_val("write_addr", obs_waddr, 32'(base));
      check_val("write_lanes", obs_wdat, exp_wdat);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr0;
    seed = 8'($urandom);
    for (int i = 0; i < 512; i++) begin
      ref_a[i] = init_byte(1'b0, 9'(i));
      ref_b[i] = init_byte(1'b1, 9'(i));
    end
    repeat (3) @(negedge clk);
    rst_b = 1'b1;

    // Asynchronous reset one cycle into the READ of an LB
    sel = 0;
    @(negedge clk);
    req_valid = 1'b1; req_op = mips_lsu_pkg::LB; req_addr = 32'h103; req_rd = 5'd9;
    @(posedge clk);
    #1 req_valid = 1'b0;
    wr0 = wr_a_cnt;
    @(negedge clk);
    rst_b = 1'b0;
    #1;
    check_val("rst_resp_valid", a_resp_valid, 0);
    check_val("rst_resp_err", a_resp_err, 0);
    check_val("rst_write_en", a_we, 0);
    check_val("rst_rdata", a_resp_rdata, 0);
    check_val("rst_rd", a_resp_rd, 0);
    check_val("rst_mem_addr", a_maddr, 0);
    check_val("rst_data_in", a_mdi, 0);
    check_val("rst_ready", a_req_ready, 1);
    @(negedge clk);
    rst_b = 1'b1;
    repeat (4) @(negedge clk);
    check_val("rst_no_write", 64'(wr_a_cnt), 64'(wr0));
    check_val("rst_ready_after", a_req_ready, 1);

    // Byte loads
    run_op(0, OP_LB, 9'h103, 64'h0, 5'd7, 0);
    check_val("lb_value", obs_rdata, 64'hFFFF_FF80);
    check_val("lb_latency", 64'(obs_lat), 3);
    check_val("lb_rd", obs_rd, 5'd7);
    run_op(0, OP_LBU, 9'h103, 64'h0, 5'd8, 0);
    check_val("lbu_value", obs_rdata, 64'h0000_0080);

    // Half loads
    run_op(0, OP_LH, 9'h102, 64'h0, 5'd3, 0);
    check_val("lh_value", obs_rdata, 64'h0000_5680);
    run_op(0, OP_LH, 9'h101, 64'h0, 5'd3, 0);
    check_val("lh_mis_err", obs_err, 1);
    check_val("lh_mis_rdata", obs_rdata, 0);
    check_val("lh_mis_latency", 64'(obs_lat), 1);

    // Sub-word store merge
    run_op(0, OP_SB, 9'h101, 64'hAABB_CCDD, 5'd0, 0);
    check_val("sb_lanes", obs_wdat, 64'h12DD_5680);
    check_val("sb_addr", obs_waddr, 32'h100);
    check_val("sb_latency", 64'(obs_lat), 4);
    check_val("sb_writes", 64'(obs_wcnt), 1);

    // Word stores
    run_op(0, OP_SW, 9'h104, 64'hDEAD_BEEF, 5'd0, 0);
    check_val("sw_lanes", obs_wdat, 64'hDEAD_BEEF);
    check_val("sw_latency", 64'(obs_lat), 2);
    run_op(0, OP_SW, 9'h106, 64'h1234_5678, 5'd0, 0);
    check_val("sw_mis_err", obs_err, 1);
    check_val("sw_mis_writes", 64'(obs_wcnt), 0);

    // Halted raised during the READ of an SH
    run_op(0, OP_SH, 9'h108, 64'h0000_CAFE, 5'd0, 1);
    check_val("halt_sh_writes", 64'(obs_wcnt), 1);
    check_val("halt_sh_latency", 64'(obs_lat), 4);
    @(negedge clk);
    check_val("halt_ready_low", req_ready, 0);
    @(negedge clk);
    check_val("halt_ready_low2", req_ready, 0);
    halted = 1'b0;
    #1 check_val("halt_ready_release", req_ready, 1);

    // 8-lane word loads
    run_op(1, OP_LW, 9'h008, 64'h0, 5'd12, 0);
    check_val("lw8_value", obs_rdata, 64'h0102_0304_0506_0708);
    run_op(1, OP_LW, 9'h00C, 64'h0, 5'd12, 0);
    check_val("lw8_mis_err", obs_err, 1);

    // Randomised traffic on both instances
    for (int i = 0; i < 120; i++) begin
      run_op(bit'(i % 2), 3'($urandom_range(0, 7)), 9'($urandom_range(0, 511)),
             {$urandom, $urandom}, 5'($urandom_range(0, 31)), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
